// File: rtl/dmem_uart_pkg.sv
// dmem_uart_tx shared definitions: register offsets, STATUS layout, FSM states.
// Optional FIFO buffer build selected by DMEM_UART_FIFO_EN.
package dmem_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_OCC   = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [7:0] status_pack(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       ovr,
    input logic [3:0] occ
  );
    logic [7:0] s;
    s           = '0;
    s[ST_BUSY]  = busy;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_OVR]   = ovr;
    s[ST_OCC+:4] = occ;
    return s;
  endfunction

endpackage

// File: rtl/dmem_uart_fifo.sv
// TX byte buffer: circular FIFO when DMEM_UART_FIFO_EN is defined,
// otherwise a single holding register. Push while full is accepted only with a pop.
module dmem_uart_fifo
  import dmem_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RSTa,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] count_o
);

`ifdef DMEM_UART_FIFO_EN

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) &&
                   (wp_q[AW] != rp_q[AW]);
  assign count_o = 4'(wp_q - rp_q);
  assign data_o  = mem_q[rp_q[AW-1:0]];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer advance; pointers carry one extra wrap bit.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push_ok) wp_d = wp_q + 1'b1;
    if (pop_ok)  rp_d = rp_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= data_i;
  end

`else

  logic [7:0] hold_q, hold_d;
  logic       vld_q, vld_d;
  logic       push_ok;

  assign full_o  = vld_q;
  assign empty_o = !vld_q;
  assign count_o = {3'b000, vld_q};
  assign data_o  = hold_q;

  assign push_ok = push_i && (!vld_q || pop_i);

  // DEPTH only sizes the FIFO build.
  if (DEPTH < 1) begin : g_depth_unused
  end

  // Holding register next state: pop empties, push refills.
  always_comb begin
    hold_d = hold_q;
    vld_d  = vld_q;
    if (pop_i) vld_d = 1'b0;
    if (push_ok) begin
      hold_d = data_i;
      vld_d  = 1'b1;
    end
  end

  // Holding register state.
  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
    end
  end

`endif

endmodule

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory bus.
// Define DMEM_UART_FIFO_EN for a FIFO_DEPTH-entry TX FIFO.
module dmem_uart_tx
  import dmem_uart_pkg::*;
#(
  parameter int               DATA_W      = 32,
  parameter int               ADD_W       = 10,
  parameter logic [ADD_W-1:0] BASE_ADDR   = 10'h3F0,
  parameter logic [15:0]      DEFAULT_DIV = 16'd867,
  parameter int               FIFO_DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RSTa,
  input  logic              WR,
  input  logic              OE,
  input  logic [ADD_W-1:0]  ADDRESS,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              SEL,
  output logic              TX,
  output logic              TX_IDLE
);

  logic [1:0]  off;
  logic        wr_en;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_data;
  logic        full;
  logic        empty;
  logic [3:0]  occ;
  logic [7:0]  status;
  logic [DATA_W-1:0] rdata;

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] period_q, period_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        ovr_q, ovr_d;
  logic        wrap;

  logic unused_data;
  assign unused_data = ^DATA_IN[DATA_W-1:16];

  assign SEL   = (ADDRESS[ADD_W-1:2] == BASE_ADDR[ADD_W-1:2]);
  assign off   = ADDRESS[1:0];
  assign wr_en = SEL && WR;
  assign push  = wr_en && (off == OFF_TXDATA);

  dmem_uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RSTa    (RSTa),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (DATA_IN[7:0]),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );

  assign status = status_pack(state_q != IDLE, full, empty,
                              ovr_q, occ);

  // Read mux; zero unless the window is selected and read.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (off == OFF_STATUS): rdata[7:0]  = status;
      (off == OFF_BAUD):   rdata[15:0] = baud_q;
      default: ;
    endcase
  end

  assign DATA_OUT = (SEL && OE) ? rdata : '0;
  assign TX       = tx_q;
  assign TX_IDLE  = (state_q == IDLE) && empty;

  // Register file writes and sticky overrun.
  always_comb begin
    baud_d = baud_q;
    ovr_d  = ovr_q;
    if (wr_en && (off == OFF_BAUD))
      baud_d = DATA_IN[15:0];
    if (wr_en && (off == OFF_STATUS) && DATA_IN[ST_OVR])
      ovr_d = 1'b0;
    if (push && full && !pop)
      ovr_d = 1'b1;
  end

  assign wrap = (cnt_q == period_q);

  // TX FSM: frame sequencing, baud counter and line level.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          period_d = baud_q;
          shreg_d  = fifo_data;
          state_d  = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d = '0;
          if (!empty) begin
            pop      = 1'b1;
            period_d = baud_q;
            shreg_d  = fifo_data;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; synchronous active-low reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      state_q  <= IDLE;
      baud_q   <= DEFAULT_DIV;
      period_q <= DEFAULT_DIV;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule
